// File: rtl/gate_truth_sweeper.sv
// gate_truth_sweeper
//   Truth-table sweeper for gate-level self-test. Drives every input vector
//   of a combinational gate under test in ascending order. Each vector is held
//   for SETTLE cycles, and the gate output is sampled on the last edge of that
//   hold. The captured table is then compared against EXPECT.
//
// Ports
//   clk       clock, all state on rising edge
//   rst_n     asynchronous active-low reset
//   start     sweep request, honoured only in IDLE
//   vec       registered input vector to the gate (vec[N_IN-1] = MSB input)
//   y         gate output
//   busy      sweep in progress
//   done      one-cycle pulse at end of sweep
//   pass      observed table == EXPECT (valid from done to next accepted start)
//   fail_idx  lowest mismatching vector (0 if none)
//   fail_cnt  number of mismatching vectors
//   obs       captured truth table, bit i = sampled y for vector i
module gate_truth_sweeper #(
  parameter int                  N_IN   = 3,
  parameter int                  SETTLE = 10,
  parameter logic [2**N_IN-1:0]  EXPECT = 8'b1000_0000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic [N_IN-1:0]    vec,
  input  logic               y,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [N_IN-1:0]    fail_idx,
  output logic [N_IN:0]      fail_cnt,
  output logic [2**N_IN-1:0] obs
);

  localparam int              CW     = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0]   RELOAD = CW'(SETTLE - 1);
  localparam logic [N_IN-1:0] LAST   = '1;

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_DONE} state_t;

  state_t        state, nxt;
  logic [CW-1:0] cnt;
  logic          sample, mismatch;

  // Compare happens on the final cycle of each vector's hold window.
  assign sample   = (state == S_SETTLE) && (cnt == '0);
  assign mismatch = sample && (y != EXPECT[vec]);

  assign busy = (state == S_SETTLE);
  assign done = (state == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:   if (start) nxt = S_SETTLE;
      S_SETTLE: if (sample && vec == LAST) nxt = S_DONE;
      S_DONE:   nxt = S_IDLE;
      default:  nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec      <= '0;
      cnt      <= '0;
      pass     <= 1'b0;
      fail_idx <= '0;
      fail_cnt <= '0;
      obs      <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          vec      <= '0;
          cnt      <= RELOAD;
          pass     <= 1'b0;
          fail_idx <= '0;
          fail_cnt <= '0;
          obs      <= '0;
        end
        S_SETTLE: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            obs[vec] <= y;
            if (mismatch) begin
              fail_cnt <= fail_cnt + 1'b1;
              // A zero count before this compare means this is the first miss.
              if (fail_cnt == '0) fail_idx <= vec;
            end
            if (vec != LAST) begin
              vec <= vec + 1'b1;
              cnt <= RELOAD;
            end else begin
              // Final compare folds in combinationally so pass is ready with done.
              pass <= (fail_cnt == '0) && !mismatch;
            end
          end
        end
        S_DONE: vec <= '0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_truth_sweeper.sv
module tb_gate_truth_sweeper;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // DUT A: defaults (3 inputs, settle 10, AND3 expected)
  logic       start_a = 1'b0;
  logic [2:0] vec_a;
  logic       y_a;
  logic       busy_a, done_a, pass_a;
  logic [2:0] fi_a;
  logic [3:0] fc_a;
  logic [7:0] obs_a;
  int         mode = 0;   // 0 AND3, 1 stuck-at-0, 2 OR3

  assign y_a = (mode == 0) ? &vec_a : (mode == 1) ? 1'b0 : |vec_a;

  gate_truth_sweeper dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .vec(vec_a), .y(y_a),
    .busy(busy_a), .done(done_a), .pass(pass_a),
    .fail_idx(fi_a), .fail_cnt(fc_a), .obs(obs_a)
  );

  // DUT B: XOR2, settle 1
  logic       start_b = 1'b0;
  logic [1:0] vec_b;
  logic       y_b;
  logic       busy_b, done_b, pass_b;
  logic [1:0] fi_b;
  logic [2:0] fc_b;
  logic [3:0] obs_b;

  assign y_b = ^vec_b;

  gate_truth_sweeper #(.N_IN(2), .SETTLE(1), .EXPECT(4'b0110)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .vec(vec_b), .y(y_b),
    .busy(busy_b), .done(done_b), .pass(pass_b),
    .fail_idx(fi_b), .fail_cnt(fc_b), .obs(obs_b)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // Sweep statistics gathered by run_a
  int busy_cyc, done_k, done_n, vec_err, fc_at0, fi_at0;

  // Pulse start on DUT A, then observe window+1 samples at E0+k (+1ns).
  // extra: re-assert start while busy (k=20) and during DONE (k=80).
  task automatic run_a(input int win, input bit extra, input bit chk_vec);
    busy_cyc = 0; done_k = -1; done_n = 0; vec_err = 0;
    @(negedge clk) start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    for (int k = 0; k <= win; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
        start_a = extra && (k == 20 || k == 80);
      end
      if (k == 0) begin fc_at0 = fc_a; fi_at0 = fi_a; end
      if (busy_a) busy_cyc++;
      if (done_a) begin done_n++; if (done_k < 0) done_k = k; end
      if (chk_vec && k < 80 && vec_a != 3'(k / 10)) vec_err++;
    end
    start_a = 1'b0;
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_vec", vec_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_pass", pass_a, 0);
    chk("rst_fc", fc_a, 0);
    chk("rst_obs", obs_a, 0);
    chk("rst_b_obs", obs_b, 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // AND3: clean pass
    mode = 0;
    run_a(100, 1'b0, 1'b0);
    chk("and_busy", busy_cyc, 80);
    chk("and_done_k", done_k, 80);
    chk("and_done_n", done_n, 1);
    chk("and_pass", pass_a, 1);
    chk("and_obs", obs_a, 8'h80);
    chk("and_fc", fc_a, 0);
    chk("and_fi", fi_a, 0);
    chk("and_vec_idle", vec_a, 0);

    // Stuck-at-0
    mode = 1;
    run_a(90, 1'b0, 1'b0);
    chk("sa0_obs", obs_a, 8'h00);
    chk("sa0_fc", fc_a, 1);
    chk("sa0_fi", fi_a, 7);
    chk("sa0_pass", pass_a, 0);

    // OR3 against AND3 expectation, plus vector hold timing
    mode = 2;
    run_a(90, 1'b0, 1'b1);
    chk("or_obs", obs_a, 8'hFE);
    chk("or_fc", fc_a, 6);
    chk("or_fi", fi_a, 1);
    chk("or_pass", pass_a, 0);
    chk("or_vec_hold", vec_err, 0);
    chk("or_done_k", done_k, 80);

    // AND3 with starts at cycle 20 and in DONE: both ignored; acceptance clears results
    mode = 0;
    run_a(100, 1'b1, 1'b0);
    chk("ign_clr_fc", fc_at0, 0);
    chk("ign_clr_fi", fi_at0, 0);
    chk("ign_done_n", done_n, 1);
    chk("ign_done_k", done_k, 80);
    chk("ign_busy", busy_cyc, 80);
    chk("ign_pass", pass_a, 1);
    chk("ign_obs", obs_a, 8'h80);

    // Async reset mid-sweep (OR3 so partial results are nonzero)
    mode = 2;
    @(negedge clk) start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    repeat (35) @(posedge clk);
    #1;
    chk("mid_fc_pre", fc_a, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_busy", busy_a, 0);
    chk("mid_vec", vec_a, 0);
    chk("mid_obs", obs_a, 0);
    chk("mid_fc", fc_a, 0);
    chk("mid_fi", fi_a, 0);
    chk("mid_pass", pass_a, 0);
    chk("mid_done", done_a, 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(negedge clk);
    mode = 0;
    run_a(90, 1'b0, 1'b0);
    chk("post_rst_done_k", done_k, 80);
    chk("post_rst_pass", pass_a, 1);
    chk("post_rst_obs", obs_a, 8'h80);

    // DUT B: XOR2, settle 1
    begin
      int dk;
      dk = -1;
      @(negedge clk) start_b = 1'b1;
      @(posedge clk); #1;
      start_b = 1'b0;
      for (int k = 1; k <= 10; k++) begin
        @(posedge clk); #1;
        if (done_b && dk < 0) dk = k;
      end
      chk("xor_done_k", dk, 4);
      chk("xor_obs", obs_b, 4'h6);
      chk("xor_pass", pass_b, 1);
      chk("xor_fc", fc_b, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
